// File: rtl/mv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mv_pkg
// Purpose  : Shared defaults, FSM state encoding and vector type for the
//            mv_mul_4x4_fp32 scheduler.
// Revision : 1.0
// ============================================================================
package mv_pkg;

   localparam int c_IDW        = 8;
   localparam int c_LATENCY    = 4;
   localparam int c_FIFO_DEPTH = 8;

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_RUN   = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;
   localparam logic [1:0] c_ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = c_ST_IDLE,
      ST_RUN   = c_ST_RUN,
      ST_DRAIN = c_ST_DRAIN,
      ST_DONE  = c_ST_DONE
   } mv_state_e;

   // x occupies the low 32 bits
   typedef struct packed {
      logic [31:0] w;
      logic [31:0] z;
      logic [31:0] y;
      logic [31:0] x;
   } vec4_t;

endpackage
`default_nettype wire

// File: rtl/mv_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : mv_out_fifo
// Purpose  : Synchronous show-ahead FIFO with occupancy count; simultaneous
//            push and pop is accepted even when full.
// Revision : 1.0
// ============================================================================
module mv_out_fifo #(
   parameter int WIDTH = 136,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int c_AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_pop;
   logic             w_push;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (c_AW+1)'(DEPTH));
   assign count  = r_count;
   assign head   = r_mem[r_rd_ptr];
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (c_AW+1)'(1);
            2'b01:   r_count <= r_count - (c_AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mv_sched_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mv_sched_ctrl
// Purpose  : Batch scheduler feeding a fixed-latency 4x4 fp32 matrix-vector
//            datapath, with credit-based issue and an in-order result buffer.
// Revision : 1.0
// ============================================================================
module mv_sched_ctrl
   import mv_pkg::*;
#(
   parameter int IDW        = c_IDW,
   parameter int LATENCY    = c_LATENCY,
   parameter int FIFO_DEPTH = c_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_start,
   input  logic [15:0]      cfg_count,
   input  logic             mat_wr_en,
   input  logic [3:0]       mat_wr_addr,
   input  logic [31:0]      mat_wr_data,
   output logic [511:0]     mat_out,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [127:0]     s_vec,
   output logic             mv_in_valid,
   output logic [IDW-1:0]   mv_in_id,
   output logic [127:0]     mv_vec,
   input  logic             mv_out_valid,
   input  logic [IDW-1:0]   mv_out_id,
   input  logic [127:0]     mv_out_vec,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [IDW-1:0]   m_id,
   output logic [127:0]     m_vec,
   output logic             busy,
   output logic             done,
   output logic             err_seq,
   output logic             err_ovf
);
   localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
   localparam int c_FW = IDW + 128;

   mv_state_e        r_state;
   mv_state_e        w_state_nxt;
   logic [15:0]      r_count;
   logic [15:0]      r_issued;
   logic [15:0]      r_retired;
   logic [15:0]      w_retired_nxt;
   logic [IDW-1:0]   r_next_id;
   logic [IDW-1:0]   r_exp_id;
   logic [c_CW-1:0]  r_inflight;
   logic [511:0]     r_mat;
   logic             r_mv_in_valid;
   logic [IDW-1:0]   r_mv_in_id;
   vec4_t            r_mv_vec;
   logic             r_err_seq;
   logic             r_err_ovf;

   logic             w_start;
   logic             w_acc;
   logic             w_res;
   logic             w_pop;
   logic             w_push;
   logic             w_ovf;
   logic             w_credit;
   logic             w_lat_ok;
   logic             w_fifo_empty;
   logic             w_fifo_full;
   logic [c_CW-1:0]  w_fifo_count;
   logic [c_FW-1:0]  w_fifo_head;

   assign w_start  = cfg_start && (r_state == ST_IDLE);
   assign w_res    = mv_out_valid && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
   assign w_pop    = m_valid && m_ready;
   assign w_push   = w_res && (!w_fifo_full || w_pop);
   assign w_ovf    = w_res && w_fifo_full && !w_pop;
   assign w_acc    = s_valid && s_ready;

   // Every issued vertex owns a buffer slot until popped, so the buffer can never overflow
   assign w_credit = ({1'b0, r_inflight} + {1'b0, w_fifo_count}) < (c_CW+1)'(FIFO_DEPTH);
   assign w_lat_ok = (r_inflight <= c_CW'(LATENCY)) || w_res;
   assign s_ready  = (r_state == ST_RUN) && (r_issued < r_count) && w_credit && w_lat_ok;

   assign w_retired_nxt = r_retired + 16'(w_pop);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (cfg_start) w_state_nxt = (cfg_count != 16'd0) ? ST_RUN : ST_DONE;
         ST_RUN:   if (r_issued == r_count) w_state_nxt = ST_DRAIN;
         ST_DRAIN: if (w_retired_nxt == r_count) w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_count       <= '0;
         r_issued      <= '0;
         r_retired     <= '0;
         r_next_id     <= '0;
         r_exp_id      <= '0;
         r_inflight    <= '0;
         r_mat         <= '0;
         r_mv_in_valid <= 1'b0;
         r_mv_in_id    <= '0;
         r_mv_vec      <= '0;
         r_err_seq     <= 1'b0;
         r_err_ovf     <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_mv_in_valid <= w_acc;
         if (w_acc) begin
            r_mv_in_id <= r_next_id;
            r_mv_vec   <= s_vec;
         end
         if (mat_wr_en && (r_state == ST_IDLE)) begin
            r_mat[{mat_wr_addr, 5'd0} +: 32] <= mat_wr_data;
         end
         if (w_start) begin
            r_count   <= cfg_count;
            r_issued  <= '0;
            r_retired <= '0;
            r_next_id <= '0;
            r_exp_id  <= '0;
         end else begin
            if (w_acc) begin
               r_next_id <= r_next_id + IDW'(1);
               r_issued  <= r_issued + 16'd1;
            end
            if (w_res) begin
               r_exp_id <= r_exp_id + IDW'(1);
            end
            if (w_pop) begin
               r_retired <= r_retired + 16'd1;
            end
         end
         case ({w_acc, w_res && (r_inflight != '0)})
            2'b10:   r_inflight <= r_inflight + c_CW'(1);
            2'b01:   r_inflight <= r_inflight - c_CW'(1);
            default: r_inflight <= r_inflight;
         endcase
         if (w_res && (mv_out_id != r_exp_id)) begin
            r_err_seq <= 1'b1;
         end
         if (w_ovf) begin
            r_err_ovf <= 1'b1;
         end
      end
   end

   mv_out_fifo #(
      .WIDTH (c_FW),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_push),
      .push_data ({mv_out_id, mv_out_vec}),
      .pop       (w_pop),
      .head      (w_fifo_head),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full),
      .count     (w_fifo_count)
   );

   assign mat_out     = r_mat;
   assign mv_in_valid = r_mv_in_valid;
   assign mv_in_id    = r_mv_in_id;
   assign mv_vec      = r_mv_vec;
   assign m_valid     = !w_fifo_empty;
   assign m_id        = w_fifo_head[c_FW-1:128];
   assign m_vec       = w_fifo_head[127:0];
   assign busy        = (r_state != ST_IDLE);
   assign done        = (r_state == ST_DONE);
   assign err_seq     = r_err_seq;
   assign err_ovf     = r_err_ovf;

endmodule
`default_nettype wire
